// File: rtl/mem_access_unit.sv
// Memory stage: issues load/store requests to the data cache and returns extended load data.
// Latency: at least 2 cycles (accept edge, ack edge); load data is registered on the ack edge.
// Backpressure: o_stall holds upstream while a legal access is being accepted or awaits ack.
module mem_access_unit #(
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 64,
    parameter int TIMEOUT    = 255
) (
    input  logic                    i_clk,
    input  logic                    i_arstn,
    input  logic                    i_mem_access,
    input  logic                    i_mem_we,
    input  logic [2:0]              i_funct3,
    input  logic [ADDR_WIDTH-1:0]   i_addr,
    input  logic [DATA_WIDTH-1:0]   i_write_data,
    input  logic                    i_flush,
    output logic                    o_dc_req,
    output logic                    o_dc_we,
    output logic [ADDR_WIDTH-1:0]   o_dc_addr,
    output logic [DATA_WIDTH-1:0]   o_dc_wdata,
    output logic [DATA_WIDTH/8-1:0] o_dc_wstrb,
    input  logic                    i_dc_ack,
    input  logic [DATA_WIDTH-1:0]   i_dc_rdata,
    output logic                    o_stall,
    output logic [DATA_WIDTH-1:0]   o_read_data,
    output logic                    o_done,
    output logic                    o_misaligned,
    output logic                    o_access_fault
);

    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int CNT_W  = $clog2(TIMEOUT + 1);

    typedef enum logic {
        ST_IDLE,
        ST_WAIT
    } state_t;

    state_t                 state_q;
    logic [CNT_W-1:0]       cnt_q;
    logic                   we_q;
    logic [2:0]             f3_q;
    logic [2:0]             off_q;
    logic                   dc_req_q;
    logic                   dc_we_q;
    logic [ADDR_WIDTH-1:0]  dc_addr_q;
    logic [DATA_WIDTH-1:0]  dc_wdata_q;
    logic [STRB_W-1:0]      dc_wstrb_q;
    logic [DATA_WIDTH-1:0]  read_data_q;
    logic                   done_q;
    logic                   misaligned_q;
    logic                   fault_q;

    logic                   accept;
    logic                   illegal;
    logic                   misaligned;
    logic                   go;
    logic [STRB_W-1:0]      size_mask;
    logic [STRB_W-1:0]      dc_wstrb_d;
    logic [DATA_WIDTH-1:0]  dc_wdata_d;
    logic [ADDR_WIDTH-1:0]  dc_addr_d;
    logic [DATA_WIDTH-1:0]  rd_shift;

    function automatic logic [DATA_WIDTH-1:0] load_extend(input logic [DATA_WIDTH-1:0] d,
                                                          input logic [2:0]            f3);
        logic sx;
        sx = ~f3[2];
        case (f3[1:0])
            2'b00:   return {{(DATA_WIDTH-8){sx & d[7]}}, d[7:0]};
            2'b01:   return {{(DATA_WIDTH-16){sx & d[15]}}, d[15:0]};
            2'b10:   return {{(DATA_WIDTH-32){sx & d[31]}}, d[31:0]};
            default: return d;
        endcase
    endfunction

    always_comb begin
        accept     = i_mem_access & ~i_flush;
        // Unsigned stores do not exist; LDU (111) does not exist on RV64.
        illegal    = i_mem_we ? i_funct3[2] : (i_funct3 == 3'b111);
        misaligned = 1'b0;
        size_mask  = '0;
        case (i_funct3[1:0])
            2'b00: begin
                misaligned = 1'b0;
                size_mask  = STRB_W'(8'h01);
            end
            2'b01: begin
                misaligned = i_addr[0];
                size_mask  = STRB_W'(8'h03);
            end
            2'b10: begin
                misaligned = |i_addr[1:0];
                size_mask  = STRB_W'(8'h0F);
            end
            default: begin
                misaligned = |i_addr[2:0];
                size_mask  = STRB_W'(8'hFF);
            end
        endcase
        go         = (state_q == ST_IDLE) & accept & ~illegal & ~misaligned;
        dc_wstrb_d = size_mask << i_addr[2:0];
        dc_wdata_d = i_write_data << {i_addr[2:0], 3'b000};
        dc_addr_d  = {i_addr[ADDR_WIDTH-1:3], 3'b000};
        rd_shift   = i_dc_rdata >> {off_q, 3'b000};
    end

    // Gated by reset so every output reads 0 while the unit is held in reset.
    assign o_stall = i_arstn & (go | ((state_q == ST_WAIT) & ~i_dc_ack));

    always_ff @(posedge i_clk or negedge i_arstn) begin
        if (!i_arstn) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            we_q         <= 1'b0;
            f3_q         <= '0;
            off_q        <= '0;
            dc_req_q     <= 1'b0;
            dc_we_q      <= 1'b0;
            dc_addr_q    <= '0;
            dc_wdata_q   <= '0;
            dc_wstrb_q   <= '0;
            read_data_q  <= '0;
            done_q       <= 1'b0;
            misaligned_q <= 1'b0;
            fault_q      <= 1'b0;
        end else begin
            done_q       <= 1'b0;
            misaligned_q <= 1'b0;
            fault_q      <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        if (illegal) begin
                            fault_q <= 1'b1;
                        end else if (misaligned) begin
                            misaligned_q <= 1'b1;
                        end else begin
                            we_q       <= i_mem_we;
                            f3_q       <= i_funct3;
                            off_q      <= i_addr[2:0];
                            dc_req_q   <= 1'b1;
                            dc_we_q    <= i_mem_we;
                            dc_addr_q  <= dc_addr_d;
                            dc_wdata_q <= dc_wdata_d;
                            dc_wstrb_q <= dc_wstrb_d;
                            cnt_q      <= '0;
                            state_q    <= ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    // Flush is ignored here: a store may already be committed at the cache.
                    if (i_dc_ack) begin
                        if (!we_q) begin
                            read_data_q <= load_extend(rd_shift, f3_q);
                        end
                        done_q   <= 1'b1;
                        dc_req_q <= 1'b0;
                        cnt_q    <= '0;
                        state_q  <= ST_IDLE;
                    end else if (cnt_q == CNT_W'(TIMEOUT)) begin
                        fault_q  <= 1'b1;
                        dc_req_q <= 1'b0;
                        cnt_q    <= '0;
                        state_q  <= ST_IDLE;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_dc_req       = dc_req_q;
    assign o_dc_we        = dc_we_q;
    assign o_dc_addr      = dc_addr_q;
    assign o_dc_wdata     = dc_wdata_q;
    assign o_dc_wstrb     = dc_wstrb_q;
    assign o_read_data    = read_data_q;
    assign o_done         = done_q;
    assign o_misaligned   = misaligned_q;
    assign o_access_fault = fault_q;

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Memory stage of the 64-bit RISC-V pipeline, sitting directly upstream of write-back.
- Takes load/store requests from the execute stage and runs a request/ack handshake with the data cache.
- Aligns and sign/zero-extends load data and registers it as read data for write-back result selection.
- Stalls the pipeline while a cache access is outstanding, and flags misaligned, illegal-size and timeout faults.

Parameters:
- ADDR_WIDTH, 64, byte address width.
- DATA_WIDTH, 64, data width; cache word width is DATA_WIDTH, so strobe width is DATA_WIDTH/8.
- TIMEOUT, 255, maximum WAIT cycles before an access fault; counter width is clog2(TIMEOUT+1).

Ports:
- i_clk  in  1  clock, rising edge.
- i_arstn  in  1  asynchronous active-low reset.
- i_mem_access  in  1  execute stage presents a load/store this cycle.
- i_mem_we  in  1  1 = store, 0 = load.
- i_funct3  in  3  access size/sign, RV64 encoding.
- i_addr  in  ADDR_WIDTH  effective address (ALU result).
- i_write_data  in  DATA_WIDTH  store data (rs2), right-aligned.
- i_flush  in  1  squash the presented access.
- o_dc_req  out  1  cache request valid.
- o_dc_we  out  1  cache write.
- o_dc_addr  out  ADDR_WIDTH  doubleword-aligned address (i_addr with [2:0] = 0).
- o_dc_wdata  out  DATA_WIDTH  store data shifted to byte lane.
- o_dc_wstrb  out  DATA_WIDTH/8  byte-write strobes.
- i_dc_ack  in  1  one-cycle completion pulse.
- i_dc_rdata  in  DATA_WIDTH  read doubleword, valid with i_dc_ack.
- o_stall  out  1  hold upstream stages.
- o_read_data  out  DATA_WIDTH  extended load result for write-back.
- o_done  out  1  one-cycle pulse, access completed.
- o_misaligned  out  1  one-cycle pulse, misaligned access.
- o_access_fault  out  1  one-cycle pulse, timeout or illegal funct3.

Behaviour:
- Reset (async, i_arstn = 0):
  - State goes to IDLE; timeout counter = 0.
  - All outputs 0, including o_read_data and all cache outputs.
- Size decode uses funct3[1:0]: 00 = byte, 01 = half, 10 = word, 11 = double.
  - funct3[2] = 1 selects zero-extension for loads.
  - Loads with funct3 = 111 are illegal.
  - Stores with funct3[2] = 1 are illegal.
- Alignment rules:
  - Half requires addr[0] = 0.
  - Word requires addr[1:0] = 0.
  - Double requires addr[2:0] = 0.
- IDLE state:
  - Accept condition: i_mem_access & ~i_flush.
  - If accepted and illegal: pulse o_access_fault next cycle; no request issued.
  - Else if accepted and misaligned: pulse o_misaligned next cycle; no request issued.
  - Else if accepted: latch we, funct3, addr[2:0], o_dc_addr, o_dc_wdata and o_dc_wstrb; go to WAIT.
  - o_dc_wdata = i_write_data << (8*addr[2:0]).
  - o_dc_wstrb = size mask (0x01/0x03/0x0F/0xFF) << addr[2:0].
- o_stall:
  - In IDLE: high combinationally when the accept condition holds and the access is legal and aligned.
  - In WAIT: high while ~i_dc_ack.
- WAIT state:
  - o_dc_req = 1; request fields are held stable until ack.
  - On i_dc_ack, for a load: o_read_data <= extend(i_dc_rdata >> (8*latched addr[2:0]), size, sign).
  - On i_dc_ack, for a store: o_read_data is unchanged.
  - On i_dc_ack: pulse o_done, clear o_dc_req, clear the counter, return to IDLE.
  - No new request is accepted in the ack cycle; the next access is seen in IDLE one cycle later.
  - Without ack, the counter increments each cycle. When the counter reaches TIMEOUT, o_access_fault pulses next cycle and the unit returns to IDLE with o_dc_req = 0.
- Latency:
  - Load data appears on o_read_data on the edge after i_dc_ack and holds until the next load completes.
  - Minimum access = 2 cycles (accept edge, ack edge).
- i_flush:
  - Honoured only in IDLE.
  - In WAIT it is ignored: the in-flight access must complete, since a store may already be committed at the cache.
- Simultaneous ack and timeout terminal count: ack wins and no fault is raised.
- i_dc_ack in IDLE is ignored.
- A reset mid-WAIT drops the request immediately; the cache must tolerate an abandoned request.

Test Plan:
- LB at addr 0x1003, i_dc_rdata = 0x0000_0000_80FF_0000 after 3 wait cycles:
  - o_stall high 4 cycles.
  - o_dc_addr = 0x1000.
  - o_read_data = 0xFFFF_FFFF_FFFF_FF80; o_done pulses once.
- LHU at 0x2006, rdata = 0x8001_0000_0000_0000:
  - o_read_data = 0x0000_0000_0000_8001.
- SW 0xDEADBEEF at 0x3004:
  - o_dc_wdata = 0xDEADBEEF_0000_0000, o_dc_wstrb = 0xF0, o_dc_we = 1.
  - o_read_data is unchanged.
- LW at 0x4002:
  - No o_dc_req; o_misaligned pulses; o_stall stays low.
  - Load with funct3 = 111: o_access_fault pulses.
- LD with no ack and TIMEOUT = 4:
  - o_dc_req high for 5 cycles, then o_access_fault pulses.
  - State returns to IDLE; a subsequent LD completes normally.
- i_flush with a valid load in IDLE: no request.
- i_flush asserted mid-WAIT: the access still completes with o_done.
- i_arstn asserted mid-WAIT: all outputs go to 0 immediately.
